pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/sparc_pipe_pkg.sv | 12 +
 rtl/pipe_hazard_cmp.sv | 20 ++
 rtl/pipe_stall_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sparc_pipe_pkg.sv
// Shared types and constants for the pipeline stall controller.
package sparc_pipe_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    LONG = 1'b1
  } state_t;

  localparam int REG_ADDR_W       = 5;
  localparam int LONG_CYCLES_DFLT = 32;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// Combinational load-use hazard detect between the ID instruction and a load in EX.
module pipe_hazard_cmp
  import sparc_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  idex_regWrite,
  input  logic                  idex_is_load,
  output logic                  hazard
);

  logic rs1_hit, rs2_hit;

  assign rs1_hit = id_rs_used[0] && (id_rs1 == idex_rd);
  assign rs2_hit = id_rs_used[1] && (id_rs2 == idex_rd);
  assign hazard  = idex_is_load && idex_regWrite && (idex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: mem stall, long mul/div occupancy, branch flush, load-use.
// Long-op support (LONG state and lcnt) is built only when PIPE_LONG_OP_EN is defined.
module pipe_stall_ctrl
  import sparc_pipe_pkg::*;
#(
  parameter int LONG_CYCLES = LONG_CYCLES_DFLT,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             id_rs1,
  input  logic [4:0]             id_rs2,
  input  logic [1:0]             id_rs_used,
  input  logic [4:0]             idex_rd,
  input  logic                   idex_regWrite,
  input  logic                   idex_is_load,
  input  logic                   ex_long_op,
  input  logic                   br_taken,
  input  logic                   mem_ready,
  output logic                   pc_hold,
  output logic                   ifid_hold,
  output logic                   ex_ready,
  output logic                   idex_bubble,
  output logic                   ifid_flush,
  output logic                   long_busy,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic hazard;
  logic hold;

  pipe_hazard_cmp u_hazard (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs_used   (id_rs_used),
    .idex_rd      (idex_rd),
    .idex_regWrite(idex_regWrite),
    .idex_is_load (idex_is_load),
    .hazard       (hazard)
  );

`ifdef PIPE_LONG_OP_EN
  localparam logic [5:0] LCNT_LOAD = 6'(LONG_CYCLES - 2);

  state_t     state, state_next;
  logic [5:0] lcnt, lcnt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      lcnt  <= '0;
    end else begin
      state <= state_next;
      lcnt  <= lcnt_next;
    end
  end

  always_comb begin
    state_next  = state;
    lcnt_next   = lcnt;
    ex_ready    = 1'b1;
    hold        = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    case (state)
      RUN: begin
        if (!mem_ready) begin
          ex_ready = 1'b0;
          hold     = 1'b1;
        end else if (ex_long_op) begin
          // the start cycle counts as the first EX cycle, so LONG runs LONG_CYCLES-1 more
          state_next = LONG;
          lcnt_next  = LCNT_LOAD;
          ex_ready   = 1'b0;
          hold       = 1'b1;
        end else if (br_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (hazard) begin
          idex_bubble = 1'b1;
          hold        = 1'b1;
        end
      end
      LONG: begin
        if (lcnt != '0) lcnt_next = lcnt - 6'd1;
        if ((lcnt != '0) || !mem_ready) begin
          ex_ready = 1'b0;
          hold     = 1'b1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign long_busy = (state == LONG);
`else
  localparam int unused_long_cycles = LONG_CYCLES;
  logic unused_long_op;
  assign unused_long_op = ex_long_op;

  always_comb begin
    ex_ready    = 1'b1;
    hold        = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!mem_ready) begin
      ex_ready = 1'b0;
      hold     = 1'b1;
    end else if (br_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (hazard) begin
      idex_bubble = 1'b1;
      hold        = 1'b1;
    end
  end

  assign long_busy = 1'b0;
`endif

  assign pc_hold   = hold;
  assign ifid_hold = hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_cnt <= '0;
    else if (!ex_ready && (stall_cnt != '1))
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed-vector bench for pipe_stall_ctrl; long-op vectors apply when PIPE_LONG_OP_EN is defined.
module tb_pipe_stall_ctrl;

  localparam int SCW = 5;
  localparam logic [SCW-1:0] SC_MAX = 5'd31;

  // {pc_hold, ifid_hold, ex_ready, idex_bubble, ifid_flush, long_busy}
  localparam logic [5:0] C_NORM  = 6'b001000;
  localparam logic [5:0] C_MEM   = 6'b110000;
  localparam logic [5:0] C_LU    = 6'b111100;
  localparam logic [5:0] C_BR    = 6'b001110;
  localparam logic [5:0] C_LSTRT = 6'b110000;
  localparam logic [5:0] C_LBUSY = 6'b110001;
  localparam logic [5:0] C_LREL  = 6'b001001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, idex_rd;
  logic [1:0] id_rs_used;
  logic idex_regWrite, idex_is_load, ex_long_op, br_taken, mem_ready;
  logic pc_hold, ifid_hold, ex_ready, idex_bubble, ifid_flush, long_busy;
  logic [SCW-1:0] stall_cnt;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [SCW-1:0] exp_sc = '0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.LONG_CYCLES(32), .STALL_CNT_W(SCW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs_used(id_rs_used),
    .idex_rd(idex_rd), .idex_regWrite(idex_regWrite), .idex_is_load(idex_is_load),
    .ex_long_op(ex_long_op), .br_taken(br_taken), .mem_ready(mem_ready),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ex_ready(ex_ready),
    .idex_bubble(idex_bubble), .ifid_flush(ifid_flush), .long_busy(long_busy),
    .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; id_rs_used = 2'b00; idex_rd = 5'd0;
    idex_regWrite = 1'b0; idex_is_load = 1'b0;
    ex_long_op = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [1:0] used);
    idex_is_load = 1'b1; idex_regWrite = 1'b1; idex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_rs_used = used;
  endtask

  // Check this cycle's control word and counter, then advance one clock.
  task automatic cyc(input string tag, input logic [5:0] exp_ctl);
    #1;
    check(tag, {26'd0, pc_hold, ifid_hold, ex_ready, idex_bubble, ifid_flush, long_busy},
          {26'd0, exp_ctl});
    check({tag, "_sc"}, {27'd0, stall_cnt}, {27'd0, exp_sc});
    if (!exp_ctl[3] && exp_sc != SC_MAX) exp_sc = exp_sc + 5'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #2;
    exp_sc = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    reset = 1'b1;
    #2;
    check("rst_ctl", {26'd0, pc_hold, ifid_hold, ex_ready, idex_bubble, ifid_flush, long_busy},
          {26'd0, C_NORM});
    check("rst_sc", {27'd0, stall_cnt}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    cyc("normal", C_NORM);

    // load-use on rs1, then the bubble has cleared the load from EX
    set_load(5'd5, 5'd5, 5'd9, 2'b01); cyc("lu_rs1", C_LU);
    idle();                            cyc("lu_after", C_NORM);
    set_load(5'd7, 5'd3, 5'd7, 2'b10); cyc("lu_rs2", C_LU);
    set_load(5'd7, 5'd3, 5'd7, 2'b01); cyc("lu_rs2_unused", C_NORM);
    set_load(5'd0, 5'd0, 5'd9, 2'b01); cyc("lu_rd0", C_NORM);
    set_load(5'd5, 5'd5, 5'd9, 2'b01); idex_regWrite = 1'b0; cyc("lu_nowr", C_NORM);
    set_load(5'd5, 5'd5, 5'd9, 2'b01); idex_is_load = 1'b0;  cyc("lu_noload", C_NORM);

    set_load(5'd5, 5'd5, 5'd9, 2'b01); br_taken = 1'b1; cyc("br_lu", C_BR);
    idle();                                             cyc("br_after", C_NORM);

    mem_ready = 1'b0; br_taken = 1'b1; cyc("mem_br", C_MEM);
    set_load(5'd5, 5'd5, 5'd9, 2'b01); cyc("mem_lu", C_MEM);
    idle(); cyc("mem_clear", C_NORM);

    // stall counter saturation
    mem_ready = 1'b0;
    for (int i = 0; i < 34; i++) cyc("mem_sat", C_MEM);
    idle(); cyc("sat_hold", C_NORM);
    check("sat_val", {27'd0, stall_cnt}, {27'd0, SC_MAX});
    do_reset();

`ifdef PIPE_LONG_OP_EN
    ex_long_op = 1'b1; cyc("long_start", C_LSTRT);
    ex_long_op = 1'b0;
    for (int i = 0; i < 30; i++) cyc("long_busy", C_LBUSY);
    cyc("long_rel", C_LREL);
    check("long_sc31", {27'd0, stall_cnt}, 32'd31);
    cyc("long_post", C_NORM);
    do_reset();

    // memory not ready when lcnt reaches 0 delays release by exactly 3 cycles
    ex_long_op = 1'b1; cyc("lm_start", C_LSTRT);
    ex_long_op = 1'b0;
    for (int i = 0; i < 30; i++) cyc("lm_busy", C_LBUSY);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("lm_memwait", C_LBUSY);
    mem_ready = 1'b1; cyc("lm_rel", C_LREL);
    cyc("lm_post", C_NORM);
    do_reset();

    // long start beats a concurrent branch
    ex_long_op = 1'b1; br_taken = 1'b1; cyc("lb_start", C_LSTRT);
    idle(); cyc("lb_busy", C_LBUSY);

    // asynchronous reset mid-LONG
    for (int i = 0; i < 8; i++) cyc("lr_busy", C_LBUSY);
    reset = 1'b1;
    #1;
    check("lr_busy0", {31'd0, long_busy}, 32'd0);
    check("lr_sc0", {27'd0, stall_cnt}, 32'd0);
    check("lr_ready", {31'd0, ex_ready}, 32'd1);
    exp_sc = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc("lr_post", C_NORM);
`else
    // ex_long_op ignored in this build
    ex_long_op = 1'b1; cyc("nolong_a", C_NORM);
    cyc("nolong_b", C_NORM);
    ex_long_op = 1'b1; br_taken = 1'b1; cyc("nolong_br", C_BR);
    idle();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("pre_rst", C_MEM);
    reset = 1'b1;
    #1;
    check("ar_sc0", {27'd0, stall_cnt}, 32'd0);
    check("ar_busy0", {31'd0, long_busy}, 32'd0);
    exp_sc = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    idle(); cyc("ar_post", C_NORM);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
